// File: rtl/load_unit_if.sv
// Load unit bus bundle: decoder/ALU issue side, memory read port and writeback.
// The slave modport is the load unit; the master modport is its environment.
interface load_unit_if #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
);
    logic            ld_valid;
    logic            ld;
    logic [2:0]      func3;
    logic [XLEN-1:0] addr;
    logic [RD_W-1:0] rd;
    logic            flush;
    logic            ld_ready;
    logic            busy;
    logic            mem_req;
    logic [XLEN-1:0] mem_addr;
    logic            mem_ack;
    logic [XLEN-1:0] mem_rdata;
    logic            wb_valid;
    logic [RD_W-1:0] wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            ld_illegal;
    logic            ld_misalign;

    modport slave (
        input  ld_valid, ld, func3, addr, rd, flush, mem_ack, mem_rdata,
        output ld_ready, busy, mem_req, mem_addr, wb_valid, wb_rd, wb_data,
               ld_illegal, ld_misalign
    );

    modport master (
        output ld_valid, ld, func3, addr, rd, flush, mem_ack, mem_rdata,
        input  ld_ready, busy, mem_req, mem_addr, wb_valid, wb_rd, wb_data,
               ld_illegal, ld_misalign
    );
endinterface

// File: rtl/load_unit.sv
// Load unit: issues one word read per load, extracts/extends byte, half or word for writeback.
// Optional macro LOAD_MISALIGN_TRAP_EN traps misaligned lh/lhu/lw instead of force-aligning them.
//
//   state   | meaning
//   IDLE    | ready for issue
//   REQ     | mem_req held until mem_ack
//   DONE    | writeback strobe (suppressed if killed)
//   FAULT   | one-cycle illegal/misalign pulse
module load_unit #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic       clk_i,
    input  logic       reset_i,
    load_unit_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DONE  = 2'd2,
        S_FAULT = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      func3_q, func3_d;
    logic [1:0]      lane_q, lane_d;
    logic [RD_W-1:0] rd_q, rd_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic            kill_q, kill_d;
    logic            mis_q, mis_d;

    logic issue;
    logic func3_legal;
    logic misaligned;

    function automatic logic [XLEN-1:0] extract(
        input logic [2:0]      f3,
        input logic [1:0]      lane,
        input logic [XLEN-1:0] word
    );
        logic [7:0]      b;
        logic [15:0]     h;
        logic [XLEN-1:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3[1:0])
            2'b00:   r = {{(XLEN-8){b[7] & ~f3[2]}}, b};
            2'b01:   r = {{(XLEN-16){h[15] & ~f3[2]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    assign issue = (state_q == S_IDLE) && bus.ld_valid && bus.ld && !bus.flush;

    always_comb begin
        func3_legal = 1'b0;
        case (bus.func3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: func3_legal = 1'b1;
            default:                                func3_legal = 1'b0;
        endcase
    end

`ifdef LOAD_MISALIGN_TRAP_EN
    assign misaligned = ((bus.func3[1:0] == 2'b01) && bus.addr[0]) ||
                        ((bus.func3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
`else
    // Misaligned half/word loads are force-aligned by the extractor lane selection.
    assign misaligned = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        func3_d    = func3_q;
        lane_d     = lane_q;
        rd_d       = rd_q;
        mem_addr_d = mem_addr_q;
        wb_data_d  = wb_data_q;
        kill_d     = kill_q;
        mis_d      = mis_q;

        case (state_q)
            S_IDLE: begin
                kill_d = 1'b0;
                if (issue) begin
                    func3_d = bus.func3;
                    lane_d  = bus.addr[1:0];
                    rd_d    = bus.rd;
                    if (!func3_legal) begin
                        mis_d   = 1'b0;
                        state_d = S_FAULT;
                    end else if (misaligned) begin
                        mis_d   = 1'b1;
                        state_d = S_FAULT;
                    end else begin
                        mem_addr_d = {bus.addr[XLEN-1:2], 2'b00};
                        state_d    = S_REQ;
                    end
                end
            end
            S_REQ: begin
                // A flush cannot withdraw the request; it only kills the writeback.
                kill_d = kill_q | bus.flush;
                if (bus.mem_ack) begin
                    wb_data_d = extract(func3_q, lane_q, bus.mem_rdata);
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                kill_d  = 1'b0;
                state_d = S_IDLE;
            end
            S_FAULT: begin
                kill_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            func3_q    <= 3'b000;
            lane_q     <= 2'b00;
            rd_q       <= '0;
            mem_addr_q <= '0;
            wb_data_q  <= '0;
            kill_q     <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            func3_q    <= func3_d;
            lane_q     <= lane_d;
            rd_q       <= rd_d;
            mem_addr_q <= mem_addr_d;
            wb_data_q  <= wb_data_d;
            kill_q     <= kill_d;
            mis_q      <= mis_d;
        end
    end

    assign bus.busy       = (state_q != S_IDLE);
    assign bus.ld_ready   = (state_q == S_IDLE);
    assign bus.mem_req    = (state_q == S_REQ);
    assign bus.mem_addr   = mem_addr_q;
    assign bus.wb_valid   = (state_q == S_DONE) && !kill_q && !bus.flush;
    assign bus.wb_rd      = rd_q;
    assign bus.wb_data    = wb_data_q;
    assign bus.ld_illegal = (state_q == S_FAULT) && !mis_q;
`ifdef LOAD_MISALIGN_TRAP_EN
    assign bus.ld_misalign = (state_q == S_FAULT) && mis_q;
`else
    assign bus.ld_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_load_unit.sv
// Directed self-checking bench for load_unit; covers both LOAD_MISALIGN_TRAP_EN builds.
module tb_load_unit;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    load_unit_if #(.XLEN(32), .RD_W(5)) bus ();

    load_unit #(.XLEN(32), .RD_W(5)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge; returns at the next negedge with the unit one cycle past the issue edge.
    task automatic do_issue(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] r);
        bus.ld_valid = 1'b1;
        bus.ld       = 1'b1;
        bus.func3    = f3;
        bus.addr     = a;
        bus.rd       = r;
        @(negedge clk);
        bus.ld_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #1;
        tests_run++;
        if (bus.ld_ready !== 1'b1 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ready: ld_ready=%b busy=%b want 1/0", bus.ld_ready, bus.busy);
        end
        tests_run++;
        if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_mem: mem_req=%b mem_addr=%h want 0/0", bus.mem_req, bus.mem_addr);
        end
        tests_run++;
        if (bus.wb_valid !== 1'b0 || bus.wb_rd !== 5'd0 || bus.wb_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_wb: wb_valid=%b wb_rd=%0d wb_data=%h want 0/0/0",
                     bus.wb_valid, bus.wb_rd, bus.wb_data);
        end
        tests_run++;
        if (bus.ld_illegal !== 1'b0 || bus.ld_misalign !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_fault: ld_illegal=%b ld_misalign=%b want 0/0",
                     bus.ld_illegal, bus.ld_misalign);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_lb_sign;
        do_issue(3'b000, 32'h0000_0103, 5'd5);
        tests_run++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0000_0100 || bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL lb_req: mem_req=%b mem_addr=%h busy=%b want 1/00000100/1",
                     bus.mem_req, bus.mem_addr, bus.busy);
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h80FF_1234;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        tests_run++;
        if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd5 || bus.wb_data !== 32'hFFFF_FF80) begin
            tests_failed++;
            $display("FAIL lb_wb: wb_valid=%b wb_rd=%0d wb_data=%h want 1/5/ffffff80",
                     bus.wb_valid, bus.wb_rd, bus.wb_data);
        end
        @(negedge clk);
        tests_run++;
        if (bus.wb_valid !== 1'b0 || bus.ld_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL lb_after: wb_valid=%b ld_ready=%b want 0/1", bus.wb_valid, bus.ld_ready);
        end
    endtask

    task automatic test_slow_lhu;
        int req_cycles;
        int stall_bad;
        req_cycles = 0;
        stall_bad  = 0;
        do_issue(3'b101, 32'h0000_0202, 5'd7);
        for (int i = 0; i < 4; i++) begin
            if (bus.mem_req === 1'b1) req_cycles++;
            if (bus.busy !== 1'b1 || bus.mem_addr !== 32'h0000_0200 || bus.wb_valid !== 1'b0)
                stall_bad++;
            if (i < 3) begin
                bus.ld_valid = (i != 1);
                bus.func3    = 3'b010;
                bus.addr     = 32'h0000_0400;
                bus.rd       = 5'd9;
            end else begin
                bus.ld_valid  = 1'b0;
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = 32'hBEEF_0000;
            end
            @(negedge clk);
        end
        bus.mem_ack = 1'b0;
        tests_run++;
        if (req_cycles !== 4 || stall_bad !== 0) begin
            tests_failed++;
            $display("FAIL lhu_hold: req_cycles=%0d bad_cycles=%0d want 4/0", req_cycles, stall_bad);
        end
        tests_run++;
        if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd7 || bus.wb_data !== 32'h0000_BEEF) begin
            tests_failed++;
            $display("FAIL lhu_wb: wb_valid=%b wb_rd=%0d wb_data=%h want 1/7/0000beef",
                     bus.wb_valid, bus.wb_rd, bus.wb_data);
        end
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (bus.mem_req !== 1'b0 || bus.ld_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL lhu_ignored_issue: mem_req=%b ld_ready=%b want 0/1", bus.mem_req, bus.ld_ready);
        end
    endtask

    task automatic test_flush_req;
        do_issue(3'b010, 32'h0000_0300, 5'd9);
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        tests_run++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0000_0300) begin
            tests_failed++;
            $display("FAIL flush_req_hold: mem_req=%b mem_addr=%h want 1/00000300", bus.mem_req, bus.mem_addr);
        end
        @(negedge clk);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h1122_3344;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        tests_run++;
        if (bus.wb_valid !== 1'b0 || bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_req_wb: wb_valid=%b busy=%b want 0/1", bus.wb_valid, bus.busy);
        end
        @(negedge clk);
        tests_run++;
        if (bus.ld_ready !== 1'b1 || bus.wb_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_req_after: ld_ready=%b wb_valid=%b want 1/0", bus.ld_ready, bus.wb_valid);
        end
    endtask

    task automatic test_flush_idle_done;
        bus.flush = 1'b1;
        do_issue(3'b010, 32'h0000_0500, 5'd4);
        bus.flush = 1'b0;
        tests_run++;
        if (bus.ld_ready !== 1'b1 || bus.mem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_idle: ld_ready=%b mem_req=%b want 1/0", bus.ld_ready, bus.mem_req);
        end
        do_issue(3'b010, 32'h0000_0500, 5'd4);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        bus.flush   = 1'b1;
        #1;
        tests_run++;
        if (bus.wb_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_done: wb_valid=%b want 0", bus.wb_valid);
        end
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        tests_run++;
        if (bus.ld_ready !== 1'b1 || bus.wb_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_done_after: ld_ready=%b wb_valid=%b want 1/0", bus.ld_ready, bus.wb_valid);
        end
    endtask

    task automatic test_illegal;
        logic [2:0] codes [3];
        codes[0] = 3'b011;
        codes[1] = 3'b110;
        codes[2] = 3'b111;
        for (int i = 0; i < 3; i++) begin
            do_issue(codes[i], 32'h0000_0600, 5'd2);
            tests_run++;
            if (bus.ld_illegal !== 1'b1 || bus.mem_req !== 1'b0 || bus.wb_valid !== 1'b0 ||
                bus.ld_misalign !== 1'b0) begin
                tests_failed++;
                $display("FAIL illegal_%0d: ld_illegal=%b mem_req=%b wb_valid=%b ld_misalign=%b want 1/0/0/0",
                         i, bus.ld_illegal, bus.mem_req, bus.wb_valid, bus.ld_misalign);
            end
            @(negedge clk);
            tests_run++;
            if (bus.ld_illegal !== 1'b0 || bus.mem_req !== 1'b0 || bus.ld_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL illegal_end_%0d: ld_illegal=%b mem_req=%b ld_ready=%b want 0/0/1",
                         i, bus.ld_illegal, bus.mem_req, bus.ld_ready);
            end
        end
    endtask

    task automatic test_misalign;
        do_issue(3'b010, 32'h0000_0106, 5'd3);
`ifdef LOAD_MISALIGN_TRAP_EN
        tests_run++;
        if (bus.ld_misalign !== 1'b1 || bus.mem_req !== 1'b0 || bus.ld_illegal !== 1'b0) begin
            tests_failed++;
            $display("FAIL misalign_trap: ld_misalign=%b mem_req=%b ld_illegal=%b want 1/0/0",
                     bus.ld_misalign, bus.mem_req, bus.ld_illegal);
        end
        @(negedge clk);
        tests_run++;
        if (bus.ld_misalign !== 1'b0 || bus.wb_valid !== 1'b0 || bus.ld_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL misalign_end: ld_misalign=%b wb_valid=%b ld_ready=%b want 0/0/1",
                     bus.ld_misalign, bus.wb_valid, bus.ld_ready);
        end
`else
        tests_run++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0000_0104 || bus.ld_misalign !== 1'b0) begin
            tests_failed++;
            $display("FAIL misalign_align: mem_req=%b mem_addr=%h ld_misalign=%b want 1/00000104/0",
                     bus.mem_req, bus.mem_addr, bus.ld_misalign);
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h1234_5678;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        tests_run++;
        if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'h1234_5678 || bus.wb_rd !== 5'd3) begin
            tests_failed++;
            $display("FAIL misalign_wb: wb_valid=%b wb_data=%h wb_rd=%0d want 1/12345678/3",
                     bus.wb_valid, bus.wb_data, bus.wb_rd);
        end
        @(negedge clk);
`endif
    endtask

    // Aligned lh/lbu extractions plus an rd=0 load that still writes back.
    task automatic test_extract;
        logic [2:0]  f3  [3];
        logic [31:0] a   [3];
        logic [4:0]  r   [3];
        logic [31:0] rdw [3];
        logic [31:0] exp [3];
        f3[0] = 3'b001; a[0] = 32'h0000_0012; r[0] = 5'd11; rdw[0] = 32'h8001_0000; exp[0] = 32'hFFFF_8001;
        f3[1] = 3'b100; a[1] = 32'h0000_0011; r[1] = 5'd12; rdw[1] = 32'h0000_9A00; exp[1] = 32'h0000_009A;
        f3[2] = 3'b000; a[2] = 32'h0000_0020; r[2] = 5'd0;  rdw[2] = 32'hAAAA_AA7F; exp[2] = 32'h0000_007F;
        for (int i = 0; i < 3; i++) begin
            do_issue(f3[i], a[i], r[i]);
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = rdw[i];
            @(negedge clk);
            bus.mem_ack = 1'b0;
            tests_run++;
            if (bus.wb_valid !== 1'b1 || bus.wb_rd !== r[i] || bus.wb_data !== exp[i]) begin
                tests_failed++;
                $display("FAIL extract_%0d: wb_valid=%b wb_rd=%0d wb_data=%h want 1/%0d/%h",
                         i, bus.wb_valid, bus.wb_rd, bus.wb_data, r[i], exp[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid;
        int wb_seen;
        wb_seen = 0;
        do_issue(3'b010, 32'h0000_0700, 5'd6);
        #2;
        reset = 1'b1;
        bus.mem_ack = 1'b0;
        #1;
        tests_run++;
        if (bus.mem_req !== 1'b0 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid: mem_req=%b busy=%b want 0/0", bus.mem_req, bus.busy);
        end
        @(negedge clk);
        reset = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.wb_valid !== 1'b0 || bus.mem_req !== 1'b0) wb_seen++;
        end
        bus.mem_ack = 1'b0;
        tests_run++;
        if (wb_seen !== 0 || bus.ld_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_after: active_cycles=%0d ld_ready=%b want 0/1", wb_seen, bus.ld_ready);
        end
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        bus.ld_valid  = 1'b0;
        bus.ld        = 1'b0;
        bus.func3     = 3'b000;
        bus.addr      = 32'h0;
        bus.rd        = 5'd0;
        bus.flush     = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        reset         = 1'b0;
        @(negedge clk);
        test_reset();
        test_lb_sign();
        test_slow_lhu();
        test_flush_req();
        test_flush_idle_done();
        test_illegal();
        test_misalign();
        test_extract();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/load_unit.md
Name: load_unit

Overview:
- Memory-read stage sitting directly downstream of the instruction sub-decoder and ALU.
- Consumes the decoder's load strobe (ld) and func3, plus the ALU-computed effective address.
- Issues a word read over a simple req/ack memory port, then extracts and extends the byte, half or word.
- Presents the result to register-file writeback. Holds the pipeline via busy while a load is outstanding.

Parameters:
- XLEN, 32, data and address width.
- RD_W, 5, destination register index width.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- ld_valid  input  1  decoded instruction is valid this cycle
- ld  input  1  decoded instruction is a load
- func3  input  3  load variant (000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu)
- addr  input  XLEN  effective address from ALU
- rd  input  RD_W  destination register index
- flush  input  1  kill the in-flight load (branch/jump redirect)
- ld_ready  output  1  unit idle, can accept an issue
- busy  output  1  load outstanding; upstream stalls
- mem_req  output  1  memory read request
- mem_addr  output  XLEN  word-aligned read address
- mem_ack  input  1  read data valid on mem_rdata
- mem_rdata  input  XLEN  read word, little-endian
- wb_valid  output  1  one-cycle writeback strobe
- wb_rd  output  RD_W  writeback register index
- wb_data  output  XLEN  extended load result
- ld_illegal  output  1  one-cycle pulse for reserved func3 (011, 110, 111)
- ld_misalign  output  1  one-cycle misalignment fault pulse; see Optional Feature

Behaviour:
- Clock and reset: single clock clk. Reset is asynchronous and active-high on reset.
- Reset values:
  - FSM goes to IDLE.
  - mem_req, wb_valid, ld_illegal, ld_misalign, busy are 0.
  - mem_addr, wb_rd, wb_data are 0.
  - ld_ready is 1.
  - Internal kill flag clears.
- Reset mid-operation abandons the load; no writeback occurs. The memory side must also be reset.
- FSM states: IDLE, REQ, DONE, FAULT.
- IDLE:
  - ld_ready=1, busy=0.
  - Issue occurs on a rising edge with ld_valid && ld && !flush. At issue, latch addr, func3 and rd.
  - Legal func3 goes to REQ. Reserved func3 goes to FAULT with cause illegal.
  - An issue attempt while not IDLE is ignored; upstream must honour busy.
- REQ:
  - mem_req=1 and mem_addr={addr[XLEN-1:2],2'b00}, both held stable until mem_ack.
  - On mem_ack, register the extracted data into wb_data and go to DONE.
  - An ack may arrive in the first REQ cycle.
- DONE:
  - wb_valid=1 for exactly one cycle (0 if the kill flag is set), with wb_rd valid. Then go to IDLE.
  - Minimum issue-to-wb_valid latency is 2 cycles: issue edge, REQ with ack, DONE.
- FAULT: pulse ld_illegal or ld_misalign for one cycle; wb_valid=0; then go to IDLE. No memory access is made.
- Extraction (lane = addr[1:0]):
  - lb/lbu select byte lane; sign- or zero-extend to XLEN.
  - lh/lhu select half addr[1]; sign- or zero-extend.
  - lw passes the full word.
- busy = (state != IDLE). ld_ready = !busy.
- flush:
  - In IDLE: blocks that cycle's issue.
  - In REQ: sets the kill flag. The request is NOT withdrawn; the FSM waits for mem_ack, and DONE produces no wb_valid.
  - In DONE: suppresses wb_valid that cycle.
  - The kill flag clears on return to IDLE.
- rd=0: the load is performed normally, with wb_valid=1 and wb_rd=0; the register file discards the write.

Optional Feature:
- Macro: LOAD_MISALIGN_TRAP_EN.
- Defined:
  - lh/lhu with addr[0]=1, or lw with addr[1:0]!=0, goes IDLE->FAULT.
  - ld_misalign pulses for one cycle; no mem_req and no writeback.
- Undefined:
  - ld_misalign is tied to 0.
  - Misaligned addresses are force-aligned: lh/lhu ignore addr[0], lw ignores addr[1:0]. The load completes normally.

Test Plan:
1. Load byte, sign-extended: lb at addr=0x103, rd=5, mem_rdata=0x80FF_1234, ack in first REQ cycle -> mem_addr=0x100; wb_valid 2 cycles after issue; wb_rd=5; wb_data=0xFFFF_FF80.
2. Load half, zero-extended, slow memory: lhu at addr=0x202, mem_rdata=0xBEEF_0000, ack 3 cycles late -> mem_req held 4 cycles; busy=1 throughout; wb_data=0x0000_BEEF; ld_valid pulses during busy are ignored.
3. Flush mid-load: lw issued, flush asserted in the second REQ cycle, ack 2 cycles later -> mem_req stays until ack; wb_valid stays 0; ld_ready=1 the next cycle.
4. Reserved func3: func3=3'b011 -> ld_illegal one-cycle pulse 1 cycle after issue; mem_req never asserted; wb_valid=0.
5. Misaligned word: lw at addr=0x106 -> with LOAD_MISALIGN_TRAP_EN, ld_misalign pulses and there is no mem_req; without it, mem_addr=0x104 and wb_data=mem_rdata.
6. Reset mid-operation: reset asserted asynchronously while in REQ -> mem_req=0 and busy=0 immediately; no wb_valid after release.
